// File: rtl/ranc_input_packet_feeder.sv
// Batch-gated spike packet FIFO feeding the grid west input.
// Releases one tick batch at a time and pulses tick once the grid settles.
module ranc_input_packet_feeder #(
  parameter int DEPTH         = 256,
  parameter int PACKET_WIDTH  = 30,
  parameter int SETTLE_CYCLES = 4,
  parameter int TICK_GAP      = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     run_en,
  input  logic                     wr_en,
  input  logic [PACKET_WIDTH-1:0]  wr_data,
  input  logic                     wr_last,
  output logic                     wr_full,
  output logic [PACKET_WIDTH-1:0]  packet_out,
  output logic                     buffer_empty,
  input  logic                     ren,
  input  logic                     grid_idle,
  output logic                     tick,
  output logic [15:0]              tick_count,
  output logic [$clog2(DEPTH):0]   batch_pending,
  output logic                     overflow_err,
  output logic                     underflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int GW = $clog2(TICK_GAP + 1);

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    DRAIN,
    TICK,
    GAP
  } state_t;

  state_t state;

  logic [PACKET_WIDTH:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [SW-1:0] settle;
  logic [GW-1:0] gap;
  logic          head_last;
  logic          pop;
  logic          wr_acc;
  logic          pend_inc;
  logic          pend_dec;

  assign head_last    = mem[rd_ptr][PACKET_WIDTH];
  assign packet_out   = mem[rd_ptr][PACKET_WIDTH-1:0];
  assign wr_full      = (count == (AW+1)'(DEPTH));
  assign buffer_empty = (state != FEED) || (count == '0);
  assign pop          = ren && !buffer_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_acc       = wr_en && (!wr_full || pop);
  assign pend_inc     = wr_acc && wr_last;
  assign pend_dec     = pop && head_last;

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= {wr_last, wr_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      batch_pending <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr_acc) - (AW+1)'(pop);
      batch_pending <= batch_pending + (AW+1)'(pend_inc)
                     - (AW+1)'(pend_dec);
      if (wr_en && !wr_acc)
        overflow_err <= 1'b1;
      if (ren && buffer_empty)
        underflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      settle     <= '0;
      gap        <= '0;
      tick       <= 1'b0;
      tick_count <= '0;
    end else begin
      tick <= 1'b0;
      unique case (state)
        IDLE: begin
          if (run_en && batch_pending != '0)
            state <= FEED;
        end
        FEED: begin
          if (pop && head_last) begin
            state  <= DRAIN;
            settle <= '0;
          end
        end
        DRAIN: begin
          if (!grid_idle) begin
            settle <= '0;
          end else if (settle == SW'(SETTLE_CYCLES - 1)) begin
            state      <= TICK;
            settle     <= '0;
            tick       <= 1'b1;
            tick_count <= tick_count + 16'd1;
          end else begin
            settle <= settle + SW'(1);
          end
        end
        TICK: begin
          state <= GAP;
          gap   <= '0;
        end
        GAP: begin
          if (gap == GW'(TICK_GAP - 1))
            state <= (run_en && batch_pending != '0) ? FEED : IDLE;
          else
            gap <= gap + GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ranc_input_packet_feeder.sv
// Directed bench for ranc_input_packet_feeder.
// Expected values are hand-derived from the batch/tick protocol.
module tb_ranc_input_packet_feeder;

  localparam int DEPTH = 256;
  localparam int PW    = 30;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          run_en;
  logic          wr_en;
  logic [PW-1:0] wr_data;
  logic          wr_last;
  logic          wr_full;
  logic [PW-1:0] packet_out;
  logic          buffer_empty;
  logic          ren;
  logic          grid_idle;
  logic          tick;
  logic [15:0]   tick_count;
  logic [8:0]    batch_pending;
  logic          overflow_err;
  logic          underflow_err;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ranc_input_packet_feeder dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .run_en        (run_en),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .wr_last       (wr_last),
    .wr_full       (wr_full),
    .packet_out    (packet_out),
    .buffer_empty  (buffer_empty),
    .ren           (ren),
    .grid_idle     (grid_idle),
    .tick          (tick),
    .tick_count    (tick_count),
    .batch_pending (batch_pending),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [PW-1:0] d, input logic last);
    wr_en   = 1'b1;
    wr_data = d;
    wr_last = last;
    step();
    wr_en   = 1'b0;
    wr_last = 1'b0;
  endtask

  logic [6:0] idle_pat;
  bit         seen;

  initial begin
    reset_n   = 1'b0;
    run_en    = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    wr_last   = 1'b0;
    ren       = 1'b0;
    grid_idle = 1'b1;
    repeat (2) step();
    chk("rst_empty", 32'(buffer_empty), 32'd1);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_tcnt", 32'(tick_count), 32'd0);
    chk("rst_pend", 32'(batch_pending), 32'd0);
    chk("rst_full", 32'(wr_full), 32'd0);
    chk("rst_errs", 32'({overflow_err, underflow_err}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // single batch of three
    put(30'h1, 1'b0);
    put(30'h2, 1'b0);
    put(30'h3, 1'b1);
    chk("b1_pend", 32'(batch_pending), 32'd1);
    chk("b1_idle_empty", 32'(buffer_empty), 32'd1);
    run_en = 1'b1;
    step();
    chk("b1_feed_empty", 32'(buffer_empty), 32'd0);
    chk("b1_pkt1", 32'(packet_out), 32'h1);
    ren = 1'b1;
    step();
    chk("b1_pkt2", 32'(packet_out), 32'h2);
    step();
    chk("b1_pkt3", 32'(packet_out), 32'h3);
    step();
    ren = 1'b0;
    chk("b1_drain_empty", 32'(buffer_empty), 32'd1);
    chk("b1_pend0", 32'(batch_pending), 32'd0);
    repeat (3) step();
    chk("b1_tick_early", 32'(tick), 32'd0);
    step();
    chk("b1_tick", 32'(tick), 32'd1);
    chk("b1_tcnt", 32'(tick_count), 32'd1);
    step();
    chk("b1_tick_pulse", 32'(tick), 32'd0);
    run_en = 1'b0;
    repeat (4) step();

    // two batches queued: 2 + 1
    put(30'hA1, 1'b0);
    put(30'hA2, 1'b1);
    put(30'hB1, 1'b1);
    chk("b2_pend2", 32'(batch_pending), 32'd2);
    run_en = 1'b1;
    step();
    chk("b2_pktA1", 32'(packet_out), 32'hA1);
    ren = 1'b1;
    step();
    chk("b2_pktA2", 32'(packet_out), 32'hA2);
    step();
    ren = 1'b0;
    chk("b2_hidden", 32'(buffer_empty), 32'd1);
    chk("b2_pend1", 32'(batch_pending), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = tick;
    end
    chk("b2_tick_seen", 32'(seen), 32'd1);
    chk("b2_tcnt", 32'(tick_count), 32'd2);
    step();
    chk("b2_gap1_empty", 32'(buffer_empty), 32'd1);
    step();
    chk("b2_gap2_empty", 32'(buffer_empty), 32'd1);
    step();
    chk("b2_feedB_empty", 32'(buffer_empty), 32'd0);
    chk("b2_pktB1", 32'(packet_out), 32'hB1);
    ren = 1'b1;
    step();
    ren = 1'b0;
    chk("b2_pend0", 32'(batch_pending), 32'd0);

    // settle counter restarts on a non-idle cycle
    idle_pat = 7'b1111011;
    for (int i = 0; i < 7; i++) begin
      grid_idle = idle_pat[i];
      chk($sformatf("settle_%0d", i), 32'(tick), 32'd0);
      step();
    end
    grid_idle = 1'b1;
    chk("settle_tick", 32'(tick), 32'd1);
    chk("settle_tcnt", 32'(tick_count), 32'd3);
    run_en = 1'b0;
    repeat (4) step();

    // read while empty
    ren = 1'b1;
    step();
    ren = 1'b0;
    chk("uf_err", 32'(underflow_err), 32'd1);
    chk("uf_no_of", 32'(overflow_err), 32'd0);

    // reset mid-batch
    put(30'h11, 1'b0);
    put(30'h12, 1'b0);
    put(30'h13, 1'b1);
    run_en = 1'b1;
    step();
    ren = 1'b1;
    step();
    ren = 1'b0;
    chk("rm_pkt", 32'(packet_out), 32'h12);
    reset_n = 1'b0;
    #1;
    chk("rm_empty", 32'(buffer_empty), 32'd1);
    chk("rm_pend", 32'(batch_pending), 32'd0);
    chk("rm_tick", 32'(tick), 32'd0);
    chk("rm_uf_clr", 32'(underflow_err), 32'd0);
    run_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("rm_idle_empty", 32'(buffer_empty), 32'd1);
    chk("rm_idle_pend", 32'(batch_pending), 32'd0);

    // fill to DEPTH, then one extra write
    for (int i = 0; i < DEPTH; i++)
      put(PW'(i), (i == DEPTH - 1));
    chk("fill_full", 32'(wr_full), 32'd1);
    chk("fill_no_of", 32'(overflow_err), 32'd0);
    put(30'h3FFFFFFF, 1'b1);
    chk("fill_of", 32'(overflow_err), 32'd1);
    chk("fill_pend", 32'(batch_pending), 32'd1);
    run_en = 1'b1;
    step();
    ren = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("fill_pkt%0d", i), 32'(packet_out), 32'(i));
      step();
    end
    ren = 1'b0;
    run_en = 1'b0;
    chk("fill_drained", 32'(buffer_empty), 32'd1);
    chk("fill_not_full", 32'(wr_full), 32'd0);
    chk("fill_pend0", 32'(batch_pending), 32'd0);
    chk("fill_no_uf", 32'(underflow_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
